// File: rtl/sine_dds_gen.sv
// -----------------------------------------------------------------------------
// sine_dds_gen
// Direct digital synthesis sine/cosine generator. A phase accumulator advances
// by a programmable tuning word. A quarter-wave lookup table, mirrored by
// quadrant, produces offset-binary sine and cosine samples through a two-stage
// pipeline.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   data       : run enable, the accumulator advances on every enabled cycle
//   ftw        : frequency tuning word (PHASE_W bits)
//   ftw_load   : one-cycle strobe that captures ftw into the tuning register
//   phase_clr  : synchronous accumulator clear
//   sineout    : sine sample, offset binary, midpoint 2^(OUT_W-1)
//   cosout     : cosine sample (sine a quarter period ahead)
//   valid      : sineout/cosout carry a fresh sample this cycle
//   wrap       : marks the first sample of a new period
// -----------------------------------------------------------------------------
module sine_dds_gen #(
  parameter int OUT_W    = 8,
  parameter int PHASE_W  = 16,
  parameter int LUT_AW   = 6,
  parameter int FTW_INIT = 32'd256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic               phase_clr,
  output logic [OUT_W-1:0]   sineout,
  output logic [OUT_W-1:0]   cosout,
  output logic               valid,
  output logic               wrap
);

  localparam int N   = 32'd1 << LUT_AW;
  localparam int AMP = (32'd1 << (OUT_W - 1)) - 32'd1;

  localparam logic [OUT_W-1:0]   MID      = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LUT_AW:0]    N_IDX    = {1'b1, {LUT_AW{1'b0}}};
  localparam logic [PHASE_W-1:0] FTW_RST  = PHASE_W'(FTW_INIT);
  localparam logic [PHASE_W-1:0] ZERO_PH  = {PHASE_W{1'b0}};

  // round(AMP * sin(pi*k/(2N))), sine evaluated by a Taylor series so the
  // table follows the parameters without an external ROM image.
  function automatic int lut_calc(input int k);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979 * real'(k) / (2.0 * real'(N));
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(real'(AMP) * sum + 0.5);
  endfunction

  // Fold a quadrant and the two mirrored table entries into an offset-binary
  // sample. Magnitudes never exceed AMP, so the result stays in 1..2^OUT_W-1.
  function automatic logic [OUT_W-1:0] quad_map(
    input logic [1:0]       q,
    input logic [OUT_W-2:0] mag_fwd,
    input logic [OUT_W-2:0] mag_rev
  );
    logic [OUT_W-1:0] res;
    case (q)
      2'd0:    res = MID + {1'b0, mag_fwd};
      2'd1:    res = MID + {1'b0, mag_rev};
      2'd2:    res = MID - {1'b0, mag_fwd};
      2'd3:    res = MID - {1'b0, mag_rev};
      default: res = MID;
    endcase
    return res;
  endfunction

  // Quarter-wave table, N+1 entries so that lut[N] (the peak) is reachable.
  logic [OUT_W-2:0] lut_s [0:N];

  for (genvar g = 0; g <= N; g++) begin : g_lut
    localparam int LUT_V = lut_calc(g);
    assign lut_s[g] = LUT_V[OUT_W-2:0];
  end

  logic [PHASE_W-1:0] acc_r;
  logic [PHASE_W-1:0] ftw_r;
  logic               wrap_pend_r;
  logic [PHASE_W:0]   sum_s;

  logic [1:0]         q1_r;
  logic [LUT_AW-1:0]  i1_r;
  logic               v1_r;
  logic               w1_r;

  logic [LUT_AW:0]    idx_fwd_s;
  logic [LUT_AW:0]    idx_rev_s;
  logic [OUT_W-1:0]   sin_s;
  logic [OUT_W-1:0]   cos_s;

  assign sum_s = {1'b0, acc_r} + {1'b0, ftw_r};

  // Accumulator, tuning register and the marker that tags the current acc as
  // the first phase of a new period (carry-out or clear of a nonzero phase).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= ZERO_PH;
      ftw_r       <= FTW_RST;
      wrap_pend_r <= 1'b0;
    end else begin
      if (ftw_load) begin
        ftw_r <= ftw;
      end
      if (phase_clr) begin
        acc_r       <= ZERO_PH;
        // A carry that landed exactly on zero and was not yet sampled still
        // belongs to the phase-zero sample that follows the clear.
        wrap_pend_r <= (acc_r != ZERO_PH) || wrap_pend_r;
      end else if (data) begin
        acc_r       <= sum_s[PHASE_W-1:0];
        wrap_pend_r <= sum_s[PHASE_W];
      end
    end
  end

  // Stage 1: split the pre-advance phase into quadrant and truncated index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1_r <= 2'd0;
      i1_r <= {LUT_AW{1'b0}};
      v1_r <= 1'b0;
      w1_r <= 1'b0;
    end else begin
      v1_r <= data;
      w1_r <= data & wrap_pend_r;
      if (data) begin
        q1_r <= acc_r[PHASE_W-1 -: 2];
        i1_r <= acc_r[PHASE_W-3 -: LUT_AW];
      end
    end
  end

  // Table lookup; cosine shares the index and sits one quadrant ahead.
  always_comb begin
    idx_fwd_s = {1'b0, i1_r};
    idx_rev_s = N_IDX - idx_fwd_s;
    sin_s     = quad_map(q1_r, lut_s[idx_fwd_s], lut_s[idx_rev_s]);
    cos_s     = quad_map(q1_r + 2'd1, lut_s[idx_fwd_s], lut_s[idx_rev_s]);
  end

  // Stage 2: registered outputs; samples hold through bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sineout <= MID;
      cosout  <= MID;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      if (v1_r) begin
        sineout <= sin_s;
        cosout  <= cos_s;
        valid   <= 1'b1;
        wrap    <= w1_r;
      end else begin
        valid   <= 1'b0;
        wrap    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_dds_gen.sv
// -----------------------------------------------------------------------------
// tb_sine_dds_gen
// Directed bench for sine_dds_gen at default parameters. A vector table checks
// single samples at chosen phases. Hand-written sequences cover reset, free
// running, retuning with a phase clear, pausing, a zero tuning word and a
// reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_sine_dds_gen;

  logic        clk;
  logic        reset;
  logic        data;
  logic [15:0] ftw;
  logic        ftw_load;
  logic        phase_clr;
  logic [7:0]  sineout;
  logic [7:0]  cosout;
  logic        valid;
  logic        wrap;

  int total;
  int bad;

  typedef struct {
    logic [15:0] ph;
    logic [7:0]  es;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] seq_s [4];
  logic [7:0] seq_c [4];

  sine_dds_gen #(
    .OUT_W(8), .PHASE_W(16), .LUT_AW(6), .FTW_INIT(256)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .ftw(ftw), .ftw_load(ftw_load),
    .phase_clr(phase_clr), .sineout(sineout), .cosout(cosout),
    .valid(valid), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int wraps;
    int first_wrap;
    int second_wrap;
    int smax;
    int smin;
    int nvalid;
    int j;

    total = 0;
    bad   = 0;

    // Phase (ftw loaded after a clear) -> expected sine/cos samples
    vecs[0] = '{16'h0000, 8'd128, 8'd255};
    vecs[1] = '{16'h4000, 8'd255, 8'd128};
    vecs[2] = '{16'h8000, 8'd128, 8'd1};
    vecs[3] = '{16'hC000, 8'd1,   8'd128};
    vecs[4] = '{16'h1000, 8'd177, 8'd245};
    vecs[5] = '{16'h2000, 8'd218, 8'd218};
    vecs[6] = '{16'h6000, 8'd218, 8'd38};
    vecs[7] = '{16'h0100, 8'd131, 8'd255};
    vecs[8] = '{16'hFFFF, 8'd125, 8'd255};
    vecs[9] = '{16'h00FF, 8'd128, 8'd255};

    seq_s[0] = 8'd128; seq_s[1] = 8'd255; seq_s[2] = 8'd128; seq_s[3] = 8'd1;
    seq_c[0] = 8'd255; seq_c[1] = 8'd128; seq_c[2] = 8'd1;   seq_c[3] = 8'd128;

    // ---------------- reset state ----------------
    reset = 1'b0; data = 1'b1; ftw = 16'h1234; ftw_load = 1'b1; phase_clr = 1'b0;
    step(); step();
    chk("rst_sine", sineout, 128);
    chk("rst_cos", cosout, 128);
    chk("rst_valid", valid, 0);
    chk("rst_wrap", wrap, 0);
    ftw_load = 1'b0;

    // ---------------- free run with FTW_INIT ----------------
    reset = 1'b1;
    wraps = 0; first_wrap = -1; second_wrap = -1; smax = 0; smin = 255; nvalid = 0;
    for (int c = 1; c <= 520; c++) begin
      step();
      if (c == 1) chk("first_valid_latency", valid, 0);
      if (c == 2) begin
        chk("first_sine", sineout, 128);
        chk("first_cos", cosout, 255);
      end
      if (c >= 2 && valid) begin
        nvalid++;
        if (sineout > smax) smax = sineout;
        if (sineout < smin) smin = sineout;
        if (wrap) begin
          wraps++;
          if (first_wrap < 0) first_wrap = c - 2;
          else second_wrap = c - 2;
        end
        if (c - 2 == 64)  chk("run_sine_64", sineout, 255);
        if (c - 2 == 192) chk("run_sine_192", sineout, 1);
        if (c - 2 == 192) chk("run_cos_192", cosout, 128);
      end
    end
    chk("run_nvalid", nvalid, 519);
    chk("run_max", smax, 255);
    chk("run_min", smin, 1);
    chk("run_wraps", wraps, 2);
    chk("run_wrap_idx0", first_wrap, 256);
    chk("run_wrap_idx1", second_wrap, 512);

    // ---------------- clear + retune to quarter steps mid-run ----------------
    ftw = 16'h4000; ftw_load = 1'b1; phase_clr = 1'b1;
    step();
    ftw_load = 1'b0; phase_clr = 1'b0;
    step();
    for (j = 0; j < 9; j++) begin
      step();
      chk("q_valid", valid, 1);
      chk("q_sine", sineout, seq_s[j % 4]);
      chk("q_cos", cosout, seq_c[j % 4]);
      chk("q_wrap", wrap, (j % 4 == 0) ? 1 : 0);
    end

    // ---------------- pause for 5 cycles and resume ----------------
    data = 1'b0;
    step();
    chk("pause_last_valid", valid, 1);
    chk("pause_last_sine", sineout, seq_s[9 % 4]);
    step();
    chk("pause_drained", valid, 0);
    chk("pause_wrap", wrap, 0);
    step(); step(); step();
    chk("pause_hold_valid", valid, 0);
    chk("pause_hold_sine", sineout, seq_s[9 % 4]);
    chk("pause_hold_cos", cosout, seq_c[9 % 4]);
    data = 1'b1;
    step();
    chk("resume_bubble", valid, 0);
    for (j = 10; j < 13; j++) begin
      step();
      chk("resume_valid", valid, 1);
      chk("resume_sine", sineout, seq_s[j % 4]);
      chk("resume_cos", cosout, seq_c[j % 4]);
      chk("resume_wrap", wrap, (j % 4 == 0) ? 1 : 0);
    end

    // ---------------- zero tuning word ----------------
    ftw = 16'h0000; ftw_load = 1'b1; phase_clr = 1'b1;
    step();
    ftw_load = 1'b0; phase_clr = 1'b0;
    step();
    step();
    chk("ftw0_clr_wrap", wrap, 1);
    chk("ftw0_clr_sine", sineout, 128);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ftw0_valid", valid, 1);
      chk("ftw0_wrap", wrap, 0);
      chk("ftw0_sine", sineout, 128);
      chk("ftw0_cos", cosout, 255);
    end

    // ---------------- single-phase vector table ----------------
    for (int v = 0; v < 10; v++) begin
      ftw = vecs[v].ph; ftw_load = 1'b1; phase_clr = 1'b1; data = 1'b0;
      step();
      ftw_load = 1'b0; phase_clr = 1'b0; data = 1'b1;
      step();
      step();
      data = 1'b0;
      step();
      chk("vec_valid", valid, 1);
      chk("vec_sine", sineout, vecs[v].es);
      chk("vec_cos", cosout, vecs[v].ec);
      step();
      chk("vec_drain", valid, 0);
      chk("vec_hold", sineout, vecs[v].es);
    end

    // ---------------- reset between edges mid-run ----------------
    data = 1'b1; ftw = 16'h0300; ftw_load = 1'b1;
    step();
    ftw_load = 1'b0;
    step(); step(); step(); step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_sine", sineout, 128);
    chk("midrst_cos", cosout, 128);
    chk("midrst_valid", valid, 0);
    chk("midrst_wrap", wrap, 0);
    @(negedge clk);
    phase_clr = 1'b1; ftw_load = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0; ftw_load = 1'b0;
    reset = 1'b1;
    step();
    chk("post_rst_bubble", valid, 0);
    step();
    chk("post_rst_valid", valid, 1);
    chk("post_rst_sine", sineout, 128);
    chk("post_rst_cos", cosout, 255);
    chk("post_rst_wrap", wrap, 0);
    step();
    chk("post_rst_step_sine", sineout, 131);
    chk("post_rst_step_cos", cosout, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
